e203_exu_lpwbck_sched: RTL and testbench
========================================

Name: e203_exu_lpwbck_sched

Overview:
- Long-pipe writeback scheduler: tracks outstanding long-pipe instructions (LSU, MULDIV, NICE) in program order in a small tracking FIFO.
- Accepts a completion only from the unit owning the FIFO head.
- Forwards each accepted completion to the longp_wbck_i_* side of the EXU writeback arbiter, or to the exception path on error.
- Also answers register-dependency queries from dispatch.

Parameters:
- DEPTH, 2, tracking FIFO entries; power of 2, minimum 2.
- N_UNIT, 3, long-pipe units; index 0=LSU, 1=MULDIV, 2=NICE.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- disp_valid  in  1  dispatch of a long-pipe instruction
- disp_ready  out  1  FIFO can accept an entry
- disp_unit  in  2  owning unit index
- disp_rdidx  in  5  destination register
- disp_rdwen  in  1  instruction writes rd
- unit_wbck_valid  in  N_UNIT  per-unit completion valid
- unit_wbck_ready  out  N_UNIT  per-unit completion ready
- unit_wbck_wdat  in  N_UNIT*XLEN  per-unit result; unit u occupies bits [u*XLEN +: XLEN]
- unit_wbck_err  in  N_UNIT  per-unit completion carries an error
- longp_wbck_o_valid  out  1  to writeback arbiter
- longp_wbck_o_ready  in  1  from writeback arbiter
- longp_wbck_o_wdat  out  XLEN  result
- longp_wbck_o_rdidx  out  5  destination
- longp_wbck_o_flags  out  5  always 0
- longp_wbck_o_rdfpu  out  1  always 0
- longp_excp_o_valid  out  1  error retire request
- longp_excp_o_ready  in  1  exception unit accepts
- longp_excp_o_unit  out  2  head unit index
- chk_rs1idx, chk_rs2idx, chk_rdidx  in  5 each  dispatch dependency query
- chk_dep  out  1  query hits an outstanding entry
- oitf_empty  out  1  no outstanding entries

Behaviour:
- Reset (async, rst_n low):
  - rptr = wptr = 0; all entry valid bits cleared.
  - Outputs while in reset: disp_ready=1, oitf_empty=1; all valid/ready outputs 0; chk_dep=0.
- Pointers are clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - full = (rptr ^ wptr) == {1, 0...}; empty = rptr == wptr.
- Dispatch:
  - disp_ready = !full. There is no same-cycle pop bypass: a full FIFO rejects dispatch even while the head is retiring.
  - On disp_valid & disp_ready, write {unit, rdidx, rdwen} at wptr; wptr increments next cycle.
- Head state: hu = head unit. cv = unit_wbck_valid[hu] & head_valid. ce = unit_wbck_err[hu].
- Routing, purely combinational from the head entry and unit inputs (zero latency):
  - longp_wbck_o_valid = cv & !ce & rdwen.
  - longp_excp_o_valid = cv & ce.
  - unit_wbck_ready[u] = head_valid & (hu==u) & (ce ? longp_excp_o_ready : rdwen ? longp_wbck_o_ready : 1).
  - unit_wbck_ready is 0 for every non-head unit. An out-of-order completion waits with no timeout.
- Retire: on a handshake with the head unit, rptr increments next cycle.
  - A completion with rdwen=0 and no error retires with no writeback.
  - wdat/rdidx outputs are driven from the head at all times; the bench checks them only when valid.
- Simultaneous dispatch and retire in one cycle: both pointers move and the count is unchanged.
- A dispatch into an empty FIFO is not retirable in the same cycle; the head becomes visible next cycle.
- chk_dep = OR over valid entries of rdwen & (rdidx == rs1 | rdidx == rs2 | rdidx == rd).
  - rdidx 0 still matches; x0 filtering belongs to dispatch.
- oitf_empty = empty, driven from registers.
- Reset asserted mid-operation drops all outstanding entries immediately; in-flight completions after reset are not accepted (unit_wbck_ready=0).

Decomposition:
- Shared package holds:
  - Unit index constants LP_UNIT_LSU=0, LP_UNIT_MDV=1, LP_UNIT_NICE=2.
  - Entry typedef {unit[1:0], rdidx[4:0], rdwen}.
  - LP_FLAGS_NONE=5'b0.
- One sub-module, e203_exu_lpwbck_fifo: entry storage, pointers, full/empty, per-entry valid vector exported for the dependency check.
- Routing and the dependency check stay in the top module.

Test Plan:
- Reset, then idle -> disp_ready=1, oitf_empty=1, all valids 0, chk_dep=0.
- Dispatch MDV rd=5, then LSU rd=6; LSU completes first with 0xAAAA -> unit_wbck_ready[0]=0 until MDV completes with 0x1234.
  - Required wbck order: (5, 0x1234), then (6, 0xAAAA). flags=0 throughout.
- Dispatch 2 with DEPTH=2 -> disp_ready=0. Head retires and a dispatch is presented the same cycle -> the dispatch is accepted only the next cycle.
- Head LSU completes with err=1, longp_excp_o_ready held 0 for 3 cycles -> excp_valid=1, excp_unit=0, wbck_valid=0, unit ready=0. Pop on the 4th cycle.
- Dispatch NICE with rdwen=0; NICE valid -> ready=1 the same cycle with longp_wbck_o_ready=0, wbck_valid=0, entry popped.
- Outstanding rd=7 -> chk_rs2idx=7 gives chk_dep=1; after its retire, chk_dep=0. An rdwen=0 entry with rdidx=7 gives chk_dep=0.

Source files
------------

// File: rtl/e203_exu_lpwbck_sched_pkg.sv
// Shared types and constants for the long-pipe writeback scheduler.
// Unit indices, the tracking-entry layout and the fixed flag value live here.
package e203_exu_lpwbck_sched_pkg;

    localparam logic [1:0] LP_UNIT_LSU  = 2'd0;
    localparam logic [1:0] LP_UNIT_MDV  = 2'd1;
    localparam logic [1:0] LP_UNIT_NICE = 2'd2;

    localparam logic [4:0] LP_FLAGS_NONE = 5'b0;

    typedef struct packed {
        logic [1:0] unit;
        logic [4:0] rdidx;
        logic       rdwen;
    } lp_entry_t;

endpackage

// File: rtl/e203_exu_lpwbck_fifo.sv
// In-order tracking FIFO of outstanding long-pipe instructions.
// Exposes the head entry and every entry with its valid bit so the parent can run dependency checks.
module e203_exu_lpwbck_fifo
    import e203_exu_lpwbck_sched_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  lp_entry_t             push_ent,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output lp_entry_t             head,
    output logic                  head_valid,
    output lp_entry_t [DEPTH-1:0] ents,
    output logic      [DEPTH-1:0] ent_vld
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] FULL_XOR = {1'b1, {AW{1'b0}}};

    logic [AW:0] rptr;
    logic [AW:0] wptr;

    // Wrap bit (MSB) distinguishes full from empty when the index bits match.
    assign full       = (rptr ^ wptr) == FULL_XOR;
    assign empty      = rptr == wptr;
    assign head       = ents[rptr[AW-1:0]];
    assign head_valid = ent_vld[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr    <= '0;
            wptr    <= '0;
            ent_vld <= '0;
            ents    <= '0;
        end else begin
            if (push) begin
                ents[wptr[AW-1:0]]    <= push_ent;
                ent_vld[wptr[AW-1:0]] <= 1'b1;
                wptr                  <= wptr + PTR_ONE;
            end
            if (pop) begin
                ent_vld[rptr[AW-1:0]] <= 1'b0;
                rptr                  <= rptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/e203_exu_lpwbck_sched.sv
// Long-pipe writeback scheduler: accepts completions only from the unit owning the FIFO head
// and routes them to the writeback arbiter or the exception path; also answers dependency queries.
module e203_exu_lpwbck_sched
    import e203_exu_lpwbck_sched_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int N_UNIT = 3,
    parameter int XLEN   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   disp_valid,
    output logic                   disp_ready,
    input  logic [1:0]             disp_unit,
    input  logic [4:0]             disp_rdidx,
    input  logic                   disp_rdwen,
    input  logic [N_UNIT-1:0]      unit_wbck_valid,
    output logic [N_UNIT-1:0]      unit_wbck_ready,
    input  logic [N_UNIT*XLEN-1:0] unit_wbck_wdat,
    input  logic [N_UNIT-1:0]      unit_wbck_err,
    output logic                   longp_wbck_o_valid,
    input  logic                   longp_wbck_o_ready,
    output logic [XLEN-1:0]        longp_wbck_o_wdat,
    output logic [4:0]             longp_wbck_o_rdidx,
    output logic [4:0]             longp_wbck_o_flags,
    output logic                   longp_wbck_o_rdfpu,
    output logic                   longp_excp_o_valid,
    input  logic                   longp_excp_o_ready,
    output logic [1:0]             longp_excp_o_unit,
    input  logic [4:0]             chk_rs1idx,
    input  logic [4:0]             chk_rs2idx,
    input  logic [4:0]             chk_rdidx,
    output logic                   chk_dep,
    output logic                   oitf_empty
);

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    lp_entry_t             head;
    logic                  head_valid;
    lp_entry_t [DEPTH-1:0] ents;
    logic      [DEPTH-1:0] ent_vld;
    lp_entry_t             push_ent;

    logic                  cv;
    logic                  ce;
    logic                  head_rdy;
    logic [XLEN-1:0]       head_wdat;

    // No pop bypass: a full FIFO stays closed even in a retiring cycle.
    assign disp_ready = !full;
    assign push       = disp_valid & !full;
    assign push_ent   = '{unit: disp_unit, rdidx: disp_rdidx, rdwen: disp_rdwen};
    assign oitf_empty = empty;

    e203_exu_lpwbck_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_ent   (push_ent),
        .pop        (pop),
        .full       (full),
        .empty      (empty),
        .head       (head),
        .head_valid (head_valid),
        .ents       (ents),
        .ent_vld    (ent_vld)
    );

    always_comb begin
        cv        = 1'b0;
        ce        = 1'b0;
        head_wdat = '0;
        for (int u = 0; u < N_UNIT; u++) begin
            if (head.unit == 2'(u)) begin
                cv        = unit_wbck_valid[u] & head_valid;
                ce        = unit_wbck_err[u];
                head_wdat = unit_wbck_wdat[u*XLEN +: XLEN];
            end
        end
    end

    // A completion with no rd write and no error retires silently.
    assign head_rdy = ce ? longp_excp_o_ready : (head.rdwen ? longp_wbck_o_ready : 1'b1);
    assign pop      = cv & head_rdy;

    always_comb begin
        unit_wbck_ready = '0;
        for (int u = 0; u < N_UNIT; u++) begin
            unit_wbck_ready[u] = head_valid & (head.unit == 2'(u)) & head_rdy;
        end
    end

    assign longp_wbck_o_valid = cv & !ce & head.rdwen;
    assign longp_wbck_o_wdat  = head_wdat;
    assign longp_wbck_o_rdidx = head.rdidx;
    assign longp_wbck_o_flags = LP_FLAGS_NONE;
    assign longp_wbck_o_rdfpu = 1'b0;
    assign longp_excp_o_valid = cv & ce;
    assign longp_excp_o_unit  = head.unit;

    // Register 0 still matches; filtering x0 is the dispatcher's job.
    always_comb begin
        chk_dep = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && ents[i].rdwen &&
                (ents[i].rdidx == chk_rs1idx || ents[i].rdidx == chk_rs2idx ||
                 ents[i].rdidx == chk_rdidx))
                chk_dep = 1'b1;
        end
    end

endmodule

// File: tb/tb_e203_exu_lpwbck_sched.sv
// Self-checking bench for the long-pipe writeback scheduler: directed scenarios plus
// randomized traffic checked against a queue-based program-order model.
module tb_e203_exu_lpwbck_sched;

    localparam int DEPTH  = 2;
    localparam int N_UNIT = 3;
    localparam int XLEN   = 32;

    logic                   clk;
    logic                   rst_n;
    logic                   disp_valid;
    logic                   disp_ready;
    logic [1:0]             disp_unit;
    logic [4:0]             disp_rdidx;
    logic                   disp_rdwen;
    logic [N_UNIT-1:0]      unit_wbck_valid;
    logic [N_UNIT-1:0]      unit_wbck_ready;
    logic [N_UNIT*XLEN-1:0] unit_wbck_wdat;
    logic [N_UNIT-1:0]      unit_wbck_err;
    logic                   longp_wbck_o_valid;
    logic                   longp_wbck_o_ready;
    logic [XLEN-1:0]        longp_wbck_o_wdat;
    logic [4:0]             longp_wbck_o_rdidx;
    logic [4:0]             longp_wbck_o_flags;
    logic                   longp_wbck_o_rdfpu;
    logic                   longp_excp_o_valid;
    logic                   longp_excp_o_ready;
    logic [1:0]             longp_excp_o_unit;
    logic [4:0]             chk_rs1idx;
    logic [4:0]             chk_rs2idx;
    logic [4:0]             chk_rdidx;
    logic                   chk_dep;
    logic                   oitf_empty;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned unit;
        int unsigned rd;
        bit          rdwen;
    } ent_t;

    e203_exu_lpwbck_sched #(.DEPTH(DEPTH), .N_UNIT(N_UNIT), .XLEN(XLEN)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .disp_valid         (disp_valid),
        .disp_ready         (disp_ready),
        .disp_unit          (disp_unit),
        .disp_rdidx         (disp_rdidx),
        .disp_rdwen         (disp_rdwen),
        .unit_wbck_valid    (unit_wbck_valid),
        .unit_wbck_ready    (unit_wbck_ready),
        .unit_wbck_wdat     (unit_wbck_wdat),
        .unit_wbck_err      (unit_wbck_err),
        .longp_wbck_o_valid (longp_wbck_o_valid),
        .longp_wbck_o_ready (longp_wbck_o_ready),
        .longp_wbck_o_wdat  (longp_wbck_o_wdat),
        .longp_wbck_o_rdidx (longp_wbck_o_rdidx),
        .longp_wbck_o_flags (longp_wbck_o_flags),
        .longp_wbck_o_rdfpu (longp_wbck_o_rdfpu),
        .longp_excp_o_valid (longp_excp_o_valid),
        .longp_excp_o_ready (longp_excp_o_ready),
        .longp_excp_o_unit  (longp_excp_o_unit),
        .chk_rs1idx         (chk_rs1idx),
        .chk_rs2idx         (chk_rs2idx),
        .chk_rdidx          (chk_rdidx),
        .chk_dep            (chk_dep),
        .oitf_empty         (oitf_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        disp_valid         = 1'b0;
        disp_unit          = 2'd0;
        disp_rdidx         = 5'd0;
        disp_rdwen         = 1'b0;
        unit_wbck_valid    = '0;
        unit_wbck_wdat     = '0;
        unit_wbck_err      = '0;
        longp_wbck_o_ready = 1'b0;
        longp_excp_o_ready = 1'b0;
        chk_rs1idx         = 5'd31;
        chk_rs2idx         = 5'd31;
        chk_rdidx          = 5'd31;
    endtask

    task automatic dispatch(input logic [1:0] u, input logic [4:0] rd, input logic we);
        disp_valid = 1'b1;
        disp_unit  = u;
        disp_rdidx = rd;
        disp_rdwen = we;
        #1;
        checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL dispatch_ready got=%b exp=1", disp_ready); end
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        unit_wbck_valid    = '1;
        longp_wbck_o_ready = 1'b1;
        longp_excp_o_ready = 1'b1;
        chk_rs1idx         = 5'd0;
        rst_n = 1'b0;
        #12;
        checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready got=%b exp=1", disp_ready); end
        checks++; if (oitf_empty !== 1'b1) begin errors++; $display("FAIL reset_oitf_empty got=%b exp=1", oitf_empty); end
        checks++; if (unit_wbck_ready !== 3'b000) begin errors++; $display("FAIL reset_unit_ready got=%b exp=000", unit_wbck_ready); end
        checks++; if ({longp_wbck_o_valid, longp_excp_o_valid} !== 2'b00) begin errors++; $display("FAIL reset_valids got=%b exp=00", {longp_wbck_o_valid, longp_excp_o_valid}); end
        checks++; if (chk_dep !== 1'b0) begin errors++; $display("FAIL reset_chk_dep got=%b exp=0", chk_dep); end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        tick();
        checks++; if (disp_ready !== 1'b1 || oitf_empty !== 1'b1) begin errors++; $display("FAIL idle_after_reset got=%b%b exp=11", disp_ready, oitf_empty); end
    endtask

    task automatic test_order();
        dispatch(2'd1, 5'd5, 1'b1);
        dispatch(2'd0, 5'd6, 1'b1);
        unit_wbck_valid[0]      = 1'b1;
        unit_wbck_wdat[31:0]    = 32'hAAAA;
        longp_wbck_o_ready      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (unit_wbck_ready[0] !== 1'b0) begin errors++; $display("FAIL ooo_lsu_ready got=%b exp=0", unit_wbck_ready[0]); end
            checks++; if (longp_wbck_o_valid !== 1'b0) begin errors++; $display("FAIL ooo_wbck_valid got=%b exp=0", longp_wbck_o_valid); end
            tick();
        end
        unit_wbck_valid[1]   = 1'b1;
        unit_wbck_wdat[63:32] = 32'h1234;
        #1;
        checks++; if (longp_wbck_o_valid !== 1'b1 || longp_wbck_o_rdidx !== 5'd5 || longp_wbck_o_wdat !== 32'h1234)
            begin errors++; $display("FAIL order_first got=%b/%0d/%h exp=1/5/1234", longp_wbck_o_valid, longp_wbck_o_rdidx, longp_wbck_o_wdat); end
        checks++; if (unit_wbck_ready !== 3'b010) begin errors++; $display("FAIL order_first_ready got=%b exp=010", unit_wbck_ready); end
        checks++; if (longp_wbck_o_flags !== 5'd0 || longp_wbck_o_rdfpu !== 1'b0) begin errors++; $display("FAIL order_flags got=%h/%b exp=0/0", longp_wbck_o_flags, longp_wbck_o_rdfpu); end
        tick();
        unit_wbck_valid[1] = 1'b0;
        #1;
        checks++; if (longp_wbck_o_valid !== 1'b1 || longp_wbck_o_rdidx !== 5'd6 || longp_wbck_o_wdat !== 32'hAAAA)
            begin errors++; $display("FAIL order_second got=%b/%0d/%h exp=1/6/aaaa", longp_wbck_o_valid, longp_wbck_o_rdidx, longp_wbck_o_wdat); end
        checks++; if (unit_wbck_ready !== 3'b001) begin errors++; $display("FAIL order_second_ready got=%b exp=001", unit_wbck_ready); end
        tick();
        idle_inputs();
        #1;
        checks++; if (oitf_empty !== 1'b1) begin errors++; $display("FAIL order_drained got=%b exp=1", oitf_empty); end
    endtask

    task automatic test_full();
        dispatch(2'd0, 5'd1, 1'b1);
        dispatch(2'd1, 5'd2, 1'b1);
        #1;
        checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL full_disp_ready got=%b exp=0", disp_ready); end
        unit_wbck_valid[0] = 1'b1;
        longp_wbck_o_ready = 1'b1;
        disp_valid = 1'b1; disp_unit = 2'd2; disp_rdidx = 5'd3; disp_rdwen = 1'b1;
        #1;
        checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass got=%b exp=0", disp_ready); end
        checks++; if (unit_wbck_ready[0] !== 1'b1) begin errors++; $display("FAIL full_head_retire got=%b exp=1", unit_wbck_ready[0]); end
        tick();
        unit_wbck_valid[0] = 1'b0;
        #1;
        checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL full_next_cycle_accept got=%b exp=1", disp_ready); end
        tick();
        disp_valid = 1'b0;
        unit_wbck_valid = 3'b110;
        unit_wbck_wdat  = {32'h3333, 32'h2222, 32'h0};
        #1;
        checks++; if (longp_wbck_o_rdidx !== 5'd2 || longp_wbck_o_wdat !== 32'h2222 || unit_wbck_ready !== 3'b010)
            begin errors++; $display("FAIL full_mdv got=%0d/%h/%b exp=2/2222/010", longp_wbck_o_rdidx, longp_wbck_o_wdat, unit_wbck_ready); end
        tick();
        #1;
        checks++; if (longp_wbck_o_rdidx !== 5'd3 || longp_wbck_o_wdat !== 32'h3333 || unit_wbck_ready !== 3'b100)
            begin errors++; $display("FAIL full_nice got=%0d/%h/%b exp=3/3333/100", longp_wbck_o_rdidx, longp_wbck_o_wdat, unit_wbck_ready); end
        tick();
        idle_inputs();
        #1;
        checks++; if (oitf_empty !== 1'b1) begin errors++; $display("FAIL full_drained got=%b exp=1", oitf_empty); end
    endtask

    task automatic test_err();
        dispatch(2'd0, 5'd9, 1'b1);
        unit_wbck_valid[0] = 1'b1;
        unit_wbck_err[0]   = 1'b1;
        longp_wbck_o_ready = 1'b1;
        longp_excp_o_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (longp_excp_o_valid !== 1'b1 || longp_excp_o_unit !== 2'd0) begin errors++; $display("FAIL err_excp got=%b/%0d exp=1/0", longp_excp_o_valid, longp_excp_o_unit); end
            checks++; if (longp_wbck_o_valid !== 1'b0 || unit_wbck_ready[0] !== 1'b0) begin errors++; $display("FAIL err_hold got=%b/%b exp=0/0", longp_wbck_o_valid, unit_wbck_ready[0]); end
            tick();
        end
        longp_excp_o_ready = 1'b1;
        #1;
        checks++; if (unit_wbck_ready[0] !== 1'b1) begin errors++; $display("FAIL err_accept got=%b exp=1", unit_wbck_ready[0]); end
        tick();
        idle_inputs();
        #1;
        checks++; if (oitf_empty !== 1'b1) begin errors++; $display("FAIL err_popped got=%b exp=1", oitf_empty); end
    endtask

    task automatic test_nord();
        dispatch(2'd2, 5'd4, 1'b0);
        unit_wbck_valid[2] = 1'b1;
        longp_wbck_o_ready = 1'b0;
        #1;
        checks++; if (unit_wbck_ready !== 3'b100) begin errors++; $display("FAIL nord_ready got=%b exp=100", unit_wbck_ready); end
        checks++; if (longp_wbck_o_valid !== 1'b0 || longp_excp_o_valid !== 1'b0) begin errors++; $display("FAIL nord_valids got=%b%b exp=00", longp_wbck_o_valid, longp_excp_o_valid); end
        tick();
        idle_inputs();
        #1;
        checks++; if (oitf_empty !== 1'b1) begin errors++; $display("FAIL nord_popped got=%b exp=1", oitf_empty); end
    endtask

    task automatic test_dep();
        dispatch(2'd1, 5'd7, 1'b1);
        chk_rs1idx = 5'd3; chk_rs2idx = 5'd7; chk_rdidx = 5'd4;
        #1;
        checks++; if (chk_dep !== 1'b1) begin errors++; $display("FAIL dep_hit got=%b exp=1", chk_dep); end
        unit_wbck_valid[1] = 1'b1;
        longp_wbck_o_ready = 1'b1;
        tick();
        unit_wbck_valid = '0;
        #1;
        checks++; if (chk_dep !== 1'b0) begin errors++; $display("FAIL dep_after_retire got=%b exp=0", chk_dep); end
        dispatch(2'd0, 5'd7, 1'b0);
        #1;
        checks++; if (chk_dep !== 1'b0) begin errors++; $display("FAIL dep_nord got=%b exp=0", chk_dep); end
        unit_wbck_valid[0] = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_midrst();
        dispatch(2'd1, 5'd8, 1'b1);
        unit_wbck_valid    = 3'b010;
        longp_wbck_o_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++; if (unit_wbck_ready !== 3'b000 || oitf_empty !== 1'b1) begin errors++; $display("FAIL midrst got=%b/%b exp=000/1", unit_wbck_ready, oitf_empty); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        #1;
        checks++; if (unit_wbck_ready !== 3'b000 || longp_wbck_o_valid !== 1'b0) begin errors++; $display("FAIL midrst_after got=%b/%b exp=000/0", unit_wbck_ready, longp_wbck_o_valid); end
        idle_inputs();
    endtask

    task automatic test_random();
        ent_t q[$];
        ent_t h;
        ent_t e;
        logic exp_wv, exp_xv, exp_dep, acc;
        logic [N_UNIT-1:0] exp_rdy;
        logic [XLEN-1:0] wd [N_UNIT];
        for (int cyc = 0; cyc < 600; cyc++) begin
            disp_valid         = ($urandom_range(0, 99) < 50);
            disp_unit          = 2'($urandom_range(0, 2));
            disp_rdidx         = 5'($urandom);
            disp_rdwen         = ($urandom_range(0, 99) < 75);
            for (int u = 0; u < N_UNIT; u++) begin
                wd[u] = $urandom;
                unit_wbck_valid[u] = ($urandom_range(0, 99) < 45);
                unit_wbck_err[u]   = ($urandom_range(0, 99) < 15);
                unit_wbck_wdat[u*XLEN +: XLEN] = wd[u];
            end
            longp_wbck_o_ready = ($urandom_range(0, 99) < 60);
            longp_excp_o_ready = ($urandom_range(0, 99) < 60);
            chk_rs1idx = 5'($urandom); chk_rs2idx = 5'($urandom); chk_rdidx = 5'($urandom);
            #1;
            exp_wv = 1'b0; exp_xv = 1'b0; exp_rdy = '0; acc = 1'b0;
            if (q.size() > 0) begin
                h = q[0];
                if (unit_wbck_err[h.unit]) acc = longp_excp_o_ready;
                else if (h.rdwen)          acc = longp_wbck_o_ready;
                else                       acc = 1'b1;
                exp_rdy[h.unit] = acc;
                exp_wv = unit_wbck_valid[h.unit] && !unit_wbck_err[h.unit] && h.rdwen;
                exp_xv = unit_wbck_valid[h.unit] && unit_wbck_err[h.unit];
            end
            exp_dep = 1'b0;
            foreach (q[i])
                if (q[i].rdwen && (q[i].rd == chk_rs1idx || q[i].rd == chk_rs2idx || q[i].rd == chk_rdidx))
                    exp_dep = 1'b1;
            checks++; if (disp_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rnd_disp_ready cyc=%0d got=%b exp=%b", cyc, disp_ready, q.size() < DEPTH); end
            checks++; if (oitf_empty !== (q.size() == 0)) begin errors++; $display("FAIL rnd_empty cyc=%0d got=%b exp=%b", cyc, oitf_empty, q.size() == 0); end
            checks++; if (unit_wbck_ready !== exp_rdy) begin errors++; $display("FAIL rnd_unit_ready cyc=%0d got=%b exp=%b", cyc, unit_wbck_ready, exp_rdy); end
            checks++; if (longp_wbck_o_valid !== exp_wv) begin errors++; $display("FAIL rnd_wbck_valid cyc=%0d got=%b exp=%b", cyc, longp_wbck_o_valid, exp_wv); end
            checks++; if (longp_excp_o_valid !== exp_xv) begin errors++; $display("FAIL rnd_excp_valid cyc=%0d got=%b exp=%b", cyc, longp_excp_o_valid, exp_xv); end
            checks++; if (chk_dep !== exp_dep) begin errors++; $display("FAIL rnd_chk_dep cyc=%0d got=%b exp=%b", cyc, chk_dep, exp_dep); end
            if (exp_wv) begin
                checks++; if (longp_wbck_o_rdidx !== 5'(h.rd) || longp_wbck_o_wdat !== wd[h.unit] || longp_wbck_o_flags !== 5'd0)
                    begin errors++; $display("FAIL rnd_wbck_data cyc=%0d got=%0d/%h exp=%0d/%h", cyc, longp_wbck_o_rdidx, longp_wbck_o_wdat, h.rd, wd[h.unit]); end
            end
            if (exp_xv) begin
                checks++; if (longp_excp_o_unit !== 2'(h.unit)) begin errors++; $display("FAIL rnd_excp_unit cyc=%0d got=%0d exp=%0d", cyc, longp_excp_o_unit, h.unit); end
            end
            if (q.size() > 0 && unit_wbck_valid[h.unit] && acc) void'(q.pop_front());
            if (disp_valid && disp_ready === 1'b1 && (q.size() < DEPTH || exp_rdy != 0)) begin
                e.unit = disp_unit; e.rd = disp_rdidx; e.rdwen = disp_rdwen;
                q.push_back(e);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b1;
        #2;
        test_reset();
        test_order();
        test_full();
        test_err();
        test_nord();
        test_dep();
        test_midrst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
